// File: rtl/conv_pkg.sv
// Shared constants for the K=4, rate-1/2 convolutional encoder framer:
// generator polynomials, framer FSM state encoding and the symbol function.
package conv_pkg;

    localparam int K = 4;

    // Generator taps, MSB = u[n], LSB = u[n-3]
    localparam logic [3:0] G1 = 4'b1101;  // octal 15 -> c1
    localparam logic [3:0] G0 = 4'b1111;  // octal 17 -> c0

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Encoded symbol {c1,c0} for the window {u[n], u[n-1], u[n-2], u[n-3]}
    function automatic logic [1:0] conv_symbol(input logic [3:0] win);
        return {^(win & G1), ^(win & G0)};
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder core: 3-bit input history plus combinational symbol generation.
// The symbol for the bit presented now is available in the same cycle; the
// history only moves when the framer actually emits that symbol.
module conv_enc_core
    import conv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic       i_bit,      // u[n]
    input  logic       i_advance,  // symbol emitted this cycle, shift history
    input  logic       i_clear,    // start of frame, zero history
    output logic [1:0] o_sym       // {c1,c0}
);

    // r_hist[0] = u[n-1], r_hist[1] = u[n-2], r_hist[2] = u[n-3]
    logic [K-2:0] r_hist;
    logic [K-1:0] w_win;

    assign w_win = {i_bit, r_hist[0], r_hist[1], r_hist[2]};
    assign o_sym = conv_symbol(w_win);

    // History shift register, cleared at frame start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
        end else if (i_clear) begin
            r_hist <= '0;
        end else if (i_advance) begin
            r_hist <= {r_hist[K-3:0], i_bit};
        end
    end

endmodule

// File: rtl/conv_enc_framer.sv
// Byte-stream to convolutional-symbol framer feeding a Viterbi decoder.
// Serialises bytes, encodes with the K=4 rate-1/2 core, appends TAIL_LEN
// flush bits, then enforces MIN_GAP idle cycles before the next frame.
// Optional feature: define CONV_ERR_INJECT_EN to add the inj_en input and
// the INJ_PERIOD parameter, which flip c0 on every INJ_PERIOD-th symbol.
// TAIL_LEN and MIN_GAP are expected to be at least 1.
module conv_enc_framer
    import conv_pkg::*;
#(
    parameter int MSB_FIRST = 1,
    parameter int TAIL_LEN  = 3,
    parameter int MIN_GAP   = 2
`ifdef CONV_ERR_INJECT_EN
    ,
    parameter logic [15:0] INJ_PERIOD = 16'd64
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       enc_enable,
    output logic [1:0] enc_d,
    output logic       frame_done,
    output logic       err_underrun
`ifdef CONV_ERR_INJECT_EN
    ,
    input  logic       inj_en
`endif
);

    localparam logic [15:0] TAIL_LAST = 16'(TAIL_LEN - 1);
    localparam logic [15:0] GAP_LAST  = 16'(MIN_GAP - 1);

    state_t      r_state;
    logic [7:0]  r_byte;
    logic        r_last;
    logic [2:0]  r_bitcnt;
    logic [15:0] r_cnt;
    logic        r_alive;
    logic        r_enable;
    logic [1:0]  r_d;
    logic        r_done_pend;
    logic        r_frame_done;
    logic        r_underrun;

    logic        w_bit7;
    logic        w_ready;
    logic        w_hs;
    logic        w_clear;
    logic        w_emit;
    logic [2:0]  w_idx;
    logic        w_bit;
    logic        w_u;
    logic [1:0]  w_sym;
    logic [1:0]  w_sym_out;

    assign w_bit7  = (r_state == ST_SHIFT) && (r_bitcnt == 3'd7);
    // r_alive keeps in_ready low until the first clock after reset release
    assign w_ready = ((r_state == ST_IDLE) && r_alive) || (w_bit7 && !r_last);
    assign w_hs    = in_valid && w_ready;
    assign w_clear = w_hs && (r_state == ST_IDLE);
    assign w_emit  = (r_state == ST_SHIFT) || (r_state == ST_TAIL);
    assign w_idx   = (MSB_FIRST != 0) ? (3'd7 - r_bitcnt) : r_bitcnt;
    assign w_bit   = r_byte[w_idx];
    assign w_u     = (r_state == ST_SHIFT) ? w_bit : 1'b0;

    conv_enc_core u_core (
        .clk       (clk),
        .rst       (rst),
        .i_bit     (w_u),
        .i_advance (w_emit),
        .i_clear   (w_clear),
        .o_sym     (w_sym)
    );

`ifdef CONV_ERR_INJECT_EN
    logic [15:0] r_injcnt;
    logic        w_inj_hit;

    assign w_inj_hit = (r_injcnt == (INJ_PERIOD - 16'd1));
    assign w_sym_out = w_sym ^ {1'b0, inj_en & w_inj_hit};

    // Emitted-symbol counter from frame start, wrapping every INJ_PERIOD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_injcnt <= '0;
        end else if (w_clear) begin
            r_injcnt <= '0;
        end else if (w_emit) begin
            r_injcnt <= w_inj_hit ? 16'd0 : (r_injcnt + 16'd1);
        end
    end
`else
    assign w_sym_out = w_sym;
`endif

    // Framer FSM: byte loading, bit/tail/gap counting and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_byte       <= '0;
            r_last       <= 1'b0;
            r_bitcnt     <= '0;
            r_cnt        <= '0;
            r_alive      <= 1'b0;
            r_done_pend  <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_alive      <= 1'b1;
            r_done_pend  <= 1'b0;
            r_underrun   <= 1'b0;
            // frame_done lands the cycle after the last tail symbol shows
            r_frame_done <= r_done_pend;
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_byte   <= in_data;
                        r_last   <= in_last;
                        r_bitcnt <= '0;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (w_bit7) begin
                        if (r_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_TAIL;
                        end else if (in_valid) begin
                            // next byte continues the stream without a bubble
                            r_byte <= in_data;
                            r_last <= in_last;
                        end else begin
                            r_underrun <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    if (r_cnt == TAIL_LAST) begin
                        r_done_pend <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Registered symbol output; zero whenever no symbol is being emitted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enable <= 1'b0;
            r_d      <= 2'b00;
        end else begin
            r_enable <= w_emit;
            r_d      <= w_emit ? w_sym_out : 2'b00;
        end
    end

    assign in_ready     = w_ready;
    assign enc_enable   = r_enable;
    assign enc_d        = r_d;
    assign frame_done   = r_frame_done;
    assign err_underrun = r_underrun;

endmodule

// File: doc/conv_enc_framer.md
CONV_ENC_FRAMER -- requirements
Module: conv_enc_framer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1; 1 = byte serialised bit 7 first, 0 = bit 0 first.
REQ-002 SHALL have parameter TAIL_LEN, default 3; zero bits appended per frame to flush the K=4 encoder.
REQ-003 SHALL have parameter MIN_GAP, default 2; minimum enc_enable-low cycles between frames.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  byte offered on in_data.
REQ-007 in_data  input  8  payload byte.
REQ-008 in_last  input  1  qualifies in_data as the final byte of the frame.
REQ-009 in_ready  output  1  block accepts the byte this cycle.
REQ-010 enc_enable  output  1  symbol stream valid; drives the Viterbi decoder enable.
REQ-011 enc_d  output  2  encoded symbol {c1,c0}; drives decoder d_in.
REQ-012 frame_done  output  1  one-cycle pulse after the last tail symbol.
REQ-013 err_underrun  output  1  one-cycle pulse when the frame is truncated by starvation.

Function
REQ-014 Encoder: rate 1/2, K=4, history u[n..n-3]; c1 = u[n]^u[n-1]^u[n-3] (octal 15), c0 = u[n]^u[n-1]^u[n-2]^u[n-3] (octal 17).
REQ-015 FSM states: IDLE, SHIFT, TAIL, GAP.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready load the byte and in_last, clear the encoder history, bit count 0, go to SHIFT.
REQ-017 SHIFT: emit one symbol per cycle with enc_enable=1; the first symbol is registered one cycle after acceptance.
REQ-018 SHIFT: in_ready=1 only in the cycle that emits bit 7 of a byte, and only if the current byte lacks in_last.
REQ-019 On that cycle with in_valid=1: load the next byte; the symbol stream SHALL stay gapless.
REQ-020 On that cycle with in_valid=0: pulse err_underrun and go to TAIL.
REQ-021 After the final bit of an in_last byte: go to TAIL.
REQ-022 TAIL: emit TAIL_LEN symbols with u[n]=0 and enc_enable=1, then pulse frame_done and go to GAP.
REQ-023 GAP: hold enc_enable=0, enc_d=2'b00 and in_ready=0 for MIN_GAP cycles, then go to IDLE.
REQ-024 Outside SHIFT and TAIL: enc_enable=0 and enc_d=2'b00.
REQ-025 in_data SHALL be sampled only on handshake; changes without handshake SHALL be ignored.

Reset
REQ-026 Asynchronous assertion SHALL force IDLE, in_ready=0 until the first clock after release, enc_enable=0, enc_d=0, frame_done=0, err_underrun=0, and clear the history and counters.
REQ-027 Reset mid-frame SHALL abandon the frame without a frame_done pulse.

Configuration
REQ-028 Macro CONV_ERR_INJECT_EN SHALL compile in an error-injection feature.
REQ-029 With the macro defined: add input inj_en (1 bit) and 16-bit parameter INJ_PERIOD (default 64).
REQ-030 With the macro defined: while inj_en=1, invert enc_d[0] on every INJ_PERIOD-th emitted symbol, counted from frame start.
REQ-031 Without the macro: no inj_en port and no injection logic; output is bit-exact clean.

Structure
REQ-032 Package conv_pkg SHALL hold the constants K=4, G1=4'b1101 and G0=4'b1111, and the FSM state enum.
REQ-033 Sub-module conv_enc_core SHALL hold the 3-bit history register and symbol generation (inputs: bit, advance, clear).

Verification
REQ-034 Single byte 0x80 with in_last, MSB_FIRST=1 -> enc_d sequence 11,11,01,11,00,00,00,00,00,00,00; 11 symbols; frame_done 1 cycle after the last.
REQ-035 Bytes 0xFF,0x00 (in_last on the 2nd) offered back-to-back -> 16+3 consecutive enc_enable=1 cycles; no gap; in_ready high exactly once mid-frame.
REQ-036 Byte 0x5A without in_last, then in_valid held low -> err_underrun pulse, 3 tail symbols, frame_done, then enc_enable low for 2 cycles.
REQ-037 rst asserted during symbol 4 of a frame -> enc_enable=0 immediately; no frame_done; the next frame starts from zero history.
REQ-038 With CONV_ERR_INJECT_EN, INJ_PERIOD=4, inj_en=1, byte 0x00 -> symbols 4 and 8 equal 01; all others 00.
